// File: rtl/clock_prescaler_pkg.sv
// clock_prescaler_pkg: shared mode encoding, default sizes and config record for the multi-channel prescaler
package clock_prescaler_pkg;

   localparam int DEF_N_CH  = 4;
   localparam int DEF_CNT_W = 24;

   typedef enum logic [1:0] {
      PM_OFF    = 2'b00,
      PM_TICK   = 2'b01,
      PM_TOGGLE = 2'b10,
      PM_RSVD   = 2'b11
   } pmode_t;

   typedef struct packed {
      logic [DEF_CNT_W-1:0] top;
      pmode_t               mode;
   } pcfg_t;

   // Reserved and OFF both leave the channel idle.
   function automatic logic is_running(pmode_t m);
      return (m == PM_TICK) || (m == PM_TOGGLE);
   endfunction

endpackage

// File: rtl/clock_prescaler_mc_channel.sv
// prescaler_channel: one divider channel with active/shadow config applied only at period boundaries
module prescaler_channel
   import clock_prescaler_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk_hw,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_top,
   input  logic [1:0]       wr_mode,
   output logic             tick,
   output logic             clk_div,
   output logic             pending
);

   logic [CNT_W-1:0] cnt, act_top, sh_top;
   pmode_t           act_mode, sh_mode, nxt_mode;
   logic             run, term, apply;

   assign run      = enable && is_running(act_mode);
   assign term     = cnt >= act_top;
   assign apply    = pending && (sync || !run || term);
   assign nxt_mode = apply ? sh_mode : act_mode;

   // Count, emit tick/divided clock, and swap in the shadow config on a boundary or while idle.
   always_ff @(posedge clk_hw or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         act_top  <= '0;
         sh_top   <= '0;
         act_mode <= PM_OFF;
         sh_mode  <= PM_OFF;
         pending  <= 1'b0;
         tick     <= 1'b0;
         clk_div  <= 1'b0;
      end else begin
         if (wr) begin
            sh_top  <= wr_top;
            sh_mode <= pmode_t'(wr_mode);
         end
         pending <= wr || (pending && !apply);
         if (apply) begin
            act_top  <= sh_top;
            act_mode <= sh_mode;
         end
         if (sync || !run) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_div <= 1'b0;
         end else if (term) begin
            cnt     <= '0;
            tick    <= 1'b1;
            clk_div <= (act_mode == PM_TOGGLE) && (nxt_mode == PM_TOGGLE) && !clk_div;
         end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clock_prescaler_mc.sv
// clock_prescaler_mc: N_CH-channel prescaler with valid/ready divisor writes; PRESCALER_PHASE_SYNC_EN adds sync_req realignment
module clock_prescaler_mc
   import clock_prescaler_pkg::*;
#(
   parameter  int N_CH  = DEF_N_CH,
   parameter  int CNT_W = DEF_CNT_W,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_hw,
   input  logic             reset_n,
`ifdef PRESCALER_PHASE_SYNC_EN
   input  logic             sync_req,
`endif
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_top,
   input  logic [1:0]       cfg_mode,
   input  logic [N_CH-1:0]  ch_enable,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  clk_div,
   output logic [N_CH-1:0]  pending
);

   logic [CH_W-1:0] ch;
   logic            in_range, sync;
   logic [N_CH-1:0] wr;

`ifdef PRESCALER_PHASE_SYNC_EN
   assign sync = sync_req;
`else
   assign sync = 1'b0;
`endif

   // A single channel ignores cfg_ch; out-of-range writes are always ready and simply dropped.
   assign ch        = (N_CH == 1) ? '0 : cfg_ch;
   assign in_range  = (N_CH == 1) || (32'(cfg_ch) < N_CH);
   assign cfg_ready = in_range ? ~pending[ch] : 1'b1;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign wr[g] = cfg_valid && cfg_ready && in_range && (ch == CH_W'(g));
      prescaler_channel #(.CNT_W(CNT_W)) u_ch (
         .clk_hw  (clk_hw),
         .reset_n (reset_n),
         .enable  (ch_enable[g]),
         .sync    (sync),
         .wr      (wr[g]),
         .wr_top  (cfg_top),
         .wr_mode (cfg_mode),
         .tick    (tick[g]),
         .clk_div (clk_div[g]),
         .pending (pending[g])
      );
   end

endmodule

// File: doc/clock_prescaler_mc.md
Name: clock_prescaler_mc

Overview:
Multi-channel programmable prescaler; successor to the single-output ROM-indexed prescaler.
- N_CH independent channels run off one hardware clock.
- Each channel generates either a one-cycle enable tick or a toggling divided clock.
- Divisors are written at runtime through a valid/ready config port and applied glitch-free at period boundaries.
- Feeds peripheral timing (UART baud, timers, display refresh) inside the SoC.

Parameters:
N_CH, 4, number of channels (1..16)
CNT_W, 24, counter/divisor width
CH_W, $clog2(N_CH) (min 1), channel index width (derived, localparam)

Ports:
clk_hw  in  1  hardware clock, all logic on posedge
reset_n  in  1  asynchronous, active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write can be accepted (combinational)
cfg_ch  in  CH_W  target channel
cfg_top  in  CNT_W  terminal count; period = cfg_top+1 cycles
cfg_mode  in  2  00 OFF, 01 TICK, 10 TOGGLE, 11 reserved (treated as OFF)
ch_enable  in  N_CH  per-channel run enable
tick  out  N_CH  registered one-cycle pulse at each terminal count (TICK and TOGGLE modes)
clk_div  out  N_CH  registered divided clock (TOGGLE mode only, else 0)
pending  out  N_CH  shadow config waiting to be applied

Behaviour:
- Reset (async, reset_n low):
  - All counters = 0; tick = 0; clk_div = 0; pending = 0.
  - Active mode = OFF; active top = 0; shadow regs = 0.
- Running (ch_enable[i]=1 and active mode != OFF), each edge:
  - If counter >= top: counter <= 0, tick[i] <= 1, and clk_div[i] <= ~clk_div[i] in TOGGLE mode.
  - Otherwise: counter <= counter+1, tick[i] <= 0.
  - Use >= so an out-of-range counter self-recovers.
  - From counter=0, the first tick is high in cycle top+1 after enable is sampled.
  - Tick period = top+1 cycles. TOGGLE period = 2*(top+1) cycles, 50% duty.
  - top=0: tick constantly high; clk_div = clk_hw/2.
- Idle (ch_enable[i]=0 or mode OFF/reserved): next edge counter <= 0, tick <= 0, clk_div <= 0. Outputs stay 0 while idle.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch].
  - A write is accepted when cfg_valid && cfg_ready, or when N_CH=1 and cfg_ch is ignored.
  - On acceptance: shadow_top/mode[cfg_ch] <= cfg_top/cfg_mode and pending[cfg_ch] <= 1.
  - If cfg_ch >= N_CH: cfg_ready = 1, the write is accepted and dropped, and no state changes.
- Apply, evaluated on the registered pending:
  - Running channel: apply on the edge where counter >= top, i.e. the terminal edge. Tick/toggle for that edge still occur; active <= shadow, counter <= 0, pending <= 0.
  - Idle channel: apply on the first edge with pending=1, i.e. one cycle after acceptance.
  - A write accepted on a terminal edge does not apply on that edge; it waits for the next boundary.
- Mode change on apply:
  - clk_div <= 0 if the new mode is not TOGGLE.
  - Switching from TOGGLE while clk_div=1 produces a final falling edge. No runt pulses shorter than one clk_hw cycle.
- Channels are fully independent. Writes to channel j never disturb channel i.

Optional Feature:
PRESCALER_PHASE_SYNC_EN
- Defined:
  - Adds input port sync_req (1 bit).
  - On an edge with sync_req=1: every channel has counter <= 0, clk_div <= 0, tick <= 0.
  - Any pending shadow is applied and pending cleared.
  - All running channels with equal top are then phase-aligned. sync_req has priority over terminal-count behaviour.
- Undefined: the port is absent; no global realignment.

Decomposition:
- Package clock_prescaler_pkg: mode enum (PM_OFF, PM_TICK, PM_TOGGLE, PM_RSVD), default CNT_W/N_CH constants, and a config struct {top, mode}.
- Sub-module prescaler_channel: counter, active/shadow regs, pending and apply logic. Instantiated N_CH times via generate.
- The top level holds only cfg decode, the cfg_ready mux, and the sync fan-out.

Test Plan:
- Reset release, write ch0 top=3 mode TICK, enable -> pending[0] clears one cycle after acceptance; tick[0] high every 4th cycle, first at cycle 4 after enable.
- ch1 top=2 mode TOGGLE -> clk_div[1] high 3 cycles / low 3 cycles; tick[1] each toggle; top=0 gives clk_hw/2.
- ch0 running top=9, write top=1 mid-period -> old 10-cycle period completes, then 2-cycle period; during the wait, a second write to ch0 sees cfg_ready=0 while a write to ch2 is accepted.
- Deassert ch_enable[1] while clk_div[1]=1 -> next edge clk_div=0, tick=0, counter restarts at 0 on re-enable; reset_n pulsed mid-count -> all outputs 0 immediately (async).
- cfg_ch=N_CH (out of range) -> write accepted, no pending bit set, no output change; mode 11 -> channel idle.
- With PRESCALER_PHASE_SYNC_EN: ch0/ch1 top=4 at different phases, pulse sync_req -> both ticks coincide every 5 cycles thereafter.
